// File: rtl/ctrl_decode_pipe.sv
// RV32I(+M) control decoder with a registered ID/EX output stage,
// load-use bubble insertion, flush, illegal flagging and perf counters.
module ctrl_decode_pipe #(
    parameter int ALUOP_W = 5,
    parameter bit EN_MEXT = 1'b1,
    parameter int CNT_W   = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [31:0]        inst_i,
    input  logic               inst_valid_i,
    output logic               inst_ready_o,
    input  logic               flush_i,
    input  logic               ex_ready_i,
    output logic               ctrl_valid_o,
    output logic               branch_o,
    output logic               mem_read_o,
    output logic               mem_to_reg_o,
    output logic               mem_write_o,
    output logic               alu_src_o,
    output logic               reg_write_o,
    output logic               reg_read1_e_o,
    output logic               reg_read2_e_o,
    output logic [ALUOP_W-1:0] alu_op_o,
    output logic [4:0]         rd_o,
    output logic [2:0]         funct3_o,
    output logic               illegal_o,
    output logic [CNT_W-1:0]   issue_cnt_o,
    output logic [CNT_W-1:0]   stall_cnt_o
);

    localparam logic [4:0] OP_NOP = 5'd0, OP_ADD = 5'd1, OP_SUB = 5'd2;
    localparam logic [4:0] OP_SLL = 5'd3, OP_SLT = 5'd4, OP_SLTU = 5'd5;
    localparam logic [4:0] OP_XOR = 5'd6, OP_SRL = 5'd7, OP_SRA = 5'd8;
    localparam logic [4:0] OP_OR = 5'd9, OP_AND = 5'd10, OP_BEQ = 5'd11;
    localparam logic [4:0] OP_BNE = 5'd12, OP_BLT = 5'd13, OP_BGE = 5'd14;
    localparam logic [4:0] OP_BLTU = 5'd15, OP_BGEU = 5'd16, OP_JAL = 5'd17;
    localparam logic [4:0] OP_LUI = 5'd18, OP_AUIPC = 5'd19, OP_MUL = 5'd20;

    typedef struct packed {
        logic               branch;
        logic               mem_read;
        logic               mem_to_reg;
        logic               mem_write;
        logic               alu_src;
        logic               reg_write;
        logic               rd1;
        logic               rd2;
        logic               illegal;
        logic [ALUOP_W-1:0] alu_op;
        logic [4:0]         rd;
        logic [2:0]         funct3;
    } bundle_t;

    bundle_t    d;
    bundle_t    q;
    logic       valid;
    logic [4:0] op;
    logic       ill;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       load_en;
    logic       hazard;

    assign opc = inst_i[6:0];
    assign f3  = inst_i[14:12];
    assign f7  = inst_i[31:25];

    always_comb begin
        d        = '0;
        d.rd     = inst_i[11:7];
        d.funct3 = f3;
        op       = OP_NOP;
        ill      = 1'b0;
        case (opc)
            7'b0010011: begin
                d.alu_src = 1'b1; d.rd1 = 1'b1; d.reg_write = 1'b1;
                case (f3)
                    3'b000: op = OP_ADD;
                    3'b010: op = OP_SLT;
                    3'b011: op = OP_SLTU;
                    3'b100: op = OP_XOR;
                    3'b110: op = OP_OR;
                    3'b111: op = OP_AND;
                    3'b001: if (f7 == 7'b0) op = OP_SLL; else ill = 1'b1;
                    default: begin
                        if (f7 == 7'b0) op = OP_SRL;
                        else if (f7 == 7'b0100000) op = OP_SRA;
                        else ill = 1'b1;
                    end
                endcase
            end
            7'b0110011: begin
                d.rd1 = 1'b1; d.rd2 = 1'b1; d.reg_write = 1'b1;
                if (f7 == 7'b0) begin
                    case (f3)
                        3'b000: op = OP_ADD;
                        3'b001: op = OP_SLL;
                        3'b010: op = OP_SLT;
                        3'b011: op = OP_SLTU;
                        3'b100: op = OP_XOR;
                        3'b101: op = OP_SRL;
                        3'b110: op = OP_OR;
                        default: op = OP_AND;
                    endcase
                end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
                    op = OP_SUB;
                end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
                    op = OP_SRA;
                end else if (f7 == 7'b0000001 && EN_MEXT) begin
                    // MUL..REMU are contiguous, indexed by funct3
                    op = OP_MUL + {2'b00, f3};
                end else begin
                    ill = 1'b1;
                end
            end
            7'b0000011: begin
                op = OP_ADD; d.alu_src = 1'b1; d.mem_read = 1'b1;
                d.mem_to_reg = 1'b1; d.reg_write = 1'b1; d.rd1 = 1'b1;
                ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            7'b0100011: begin
                op = OP_ADD; d.alu_src = 1'b1; d.mem_write = 1'b1;
                d.rd1 = 1'b1; d.rd2 = 1'b1;
                ill = f3[2] || (f3 == 3'b011);
            end
            7'b1100011: begin
                d.branch = 1'b1; d.rd1 = 1'b1; d.rd2 = 1'b1;
                case (f3)
                    3'b000: op = OP_BEQ;
                    3'b001: op = OP_BNE;
                    3'b100: op = OP_BLT;
                    3'b101: op = OP_BGE;
                    3'b110: op = OP_BLTU;
                    3'b111: op = OP_BGEU;
                    default: ill = 1'b1;
                endcase
            end
            7'b1101111: begin
                op = OP_JAL; d.reg_write = 1'b1;
            end
            7'b1100111: begin
                op = OP_JAL; d.rd1 = 1'b1; d.reg_write = 1'b1;
                d.alu_src = 1'b1; ill = (f3 != 3'b000);
            end
            7'b0110111: begin
                op = OP_LUI; d.alu_src = 1'b1; d.reg_write = 1'b1;
            end
            7'b0010111: begin
                op = OP_AUIPC; d.alu_src = 1'b1; d.reg_write = 1'b1;
            end
            default: ill = 1'b1;
        endcase
        d.alu_op = ALUOP_W'(op);
        if (ill) begin
            d        = '0;
            d.rd     = inst_i[11:7];
            d.funct3 = f3;
            d.illegal = 1'b1;
        end
    end

    assign load_en = !valid || ex_ready_i;
    assign hazard  = inst_valid_i && valid && q.mem_read && (q.rd != 5'd0)
                  && ((d.rd1 && inst_i[19:15] == q.rd)
                   || (d.rd2 && inst_i[24:20] == q.rd));
    assign inst_ready_o = rst_i && (flush_i || (load_en && !hazard));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid       <= 1'b0;
            q           <= '0;
            issue_cnt_o <= '0;
            stall_cnt_o <= '0;
        end else if (flush_i) begin
            valid <= 1'b0;
            q     <= '0;
        end else begin
            if (valid && ex_ready_i)
                issue_cnt_o <= issue_cnt_o + 1'b1;
            if (load_en) begin
                if (hazard) begin
                    valid       <= 1'b0;
                    q           <= '0;
                    stall_cnt_o <= stall_cnt_o + 1'b1;
                end else if (inst_valid_i) begin
                    valid <= 1'b1;
                    q     <= d;
                end else begin
                    valid <= 1'b0;
                    q     <= '0;
                end
            end
        end
    end

    assign ctrl_valid_o  = valid;
    assign branch_o      = q.branch;
    assign mem_read_o    = q.mem_read;
    assign mem_to_reg_o  = q.mem_to_reg;
    assign mem_write_o   = q.mem_write;
    assign alu_src_o     = q.alu_src;
    assign reg_write_o   = q.reg_write;
    assign reg_read1_e_o = q.rd1;
    assign reg_read2_e_o = q.rd2;
    assign alu_op_o      = q.alu_op;
    assign rd_o          = q.rd;
    assign funct3_o      = q.funct3;
    assign illegal_o     = q.illegal;

endmodule

// File: doc/ctrl_decode_pipe.md
Name: ctrl_decode_pipe

Overview:
Registered, parametrised successor to the combinational control decoder. It decodes RV32I plus optional RV32M into the same control bundle (branch, mem read/write, mem-to-reg, ALU source, reg write, read enables, ALU op) and holds it in an ID/EX output register. The register uses a valid/ready handshake. The block also adds load-use hazard bubbles, flush, illegal-instruction flagging and issue/stall counters. It sits between the fetch buffer and the EX stage.

Parameters:
- ALUOP_W, 5, width of alu_op_o; must be ≥5.
- EN_MEXT, 1, 1 decodes MUL/DIV/REM; 0 flags them illegal.
- CNT_W, 16, width of the performance counters; they wrap.

Ports:
- clk_i  in  1  clock; all state is updated on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- inst_i  in  32  instruction word from fetch.
- inst_valid_i  in  1  inst_i is valid.
- inst_ready_o  out  1  decoder accepts inst_i this cycle.
- flush_i  in  1  kill the output register contents and the incoming instruction.
- ex_ready_i  in  1  EX accepts the output register this cycle.
- ctrl_valid_o  out  1  output register holds a real instruction.
- branch_o, mem_read_o, mem_to_reg_o, mem_write_o, alu_src_o, reg_write_o, reg_read1_e_o, reg_read2_e_o  out  1 each  control bundle; alu_src_o=1 selects the immediate.
- alu_op_o  out  ALUOP_W  ALU operation code.
- rd_o  out  5  destination register, inst[11:7].
- funct3_o  out  3  inst[14:12]; gives load/store size to MEM.
- illegal_o  out  1  registered instruction is undecodable.
- issue_cnt_o  out  CNT_W  count of instructions accepted by EX.
- stall_cnt_o  out  CNT_W  count of cycles in which a hazard bubble was inserted.

Behaviour:
- Reset (rst_i=0, asynchronous): every output and counter clears to 0 and alu_op_o=NOP; inst_ready_o=0 while reset is held.
- ALU op codes: NOP 0, ADD 1, SUB 2, SLL 3, SLT 4, SLTU 5, XOR 6, SRL 7, SRA 8, OR 9, AND 10, BEQ 11, BNE 12, BLT 13, BGE 14, BLTU 15, BGEU 16, JAL 17, LUI 18, AUIPC 19, MUL 20, MULH 21, MULHSU 22, MULHU 23, DIV 24, DIVU 25, REM 26, REMU 27. Codes are zero-extended to ALUOP_W.
- OP-IMM: alu_src=1, rd1=1, rd2=0, reg_write=1. SRLI/SRAI are selected by inst[30].
- OP (R-type): alu_src=0, rd1=1, rd2=1, reg_write=1, including SLL/SRL/SRA. funct7 0100000 selects SUB/SRA. funct7 0000001 selects the M ops when EN_MEXT=1.
- LOAD: ADD, alu_src=1, mem_read=1, mem_to_reg=1, reg_write=1, rd1=1.
- STORE: ADD, alu_src=1, mem_write=1, rd1=1, rd2=1.
- BRANCH: branch=1, rd1=1, rd2=1, op BEQ..BGEU.
- JAL: JAL op, reg_write=1.
- JALR: JAL op, rd1=1, reg_write=1, alu_src=1.
- LUI/AUIPC: alu_src=1, reg_write=1.
- Illegal: any other opcode/funct3/funct7 combination, or an M op with EN_MEXT=0. Registered as valid with illegal_o=1, all write/memory/branch strobes 0, alu_op NOP.
- load_en = !ctrl_valid_o || ex_ready_i.
- Hazard condition: the output register is valid and mem_read_o=1 with rd_o≠0, and the incoming instruction reads that register (rs1 = inst[19:15] with rd1 enabled, or rs2 = inst[24:20] with rd2 enabled).
- inst_ready_o = load_en && !hazard. On a hazard with load_en, the register loads a bubble (ctrl_valid_o=0, all strobes 0) and stall_cnt_o increments.
- Priority: reset > flush > hazard > normal.
  - Flush: the next state is ctrl_valid_o=0 regardless of ex_ready_i. inst_ready_o=1 so fetch drops its word. No counter changes.
- Holding: when ctrl_valid_o=1 and ex_ready_i=0, all outputs hold stable; inst_ready_o=0.
- issue_cnt_o increments on ctrl_valid_o && ex_ready_i. Both counters wrap at 2^CNT_W.
- Latency: 1 cycle from acceptance to ctrl_valid_o. Full throughput is 1 instruction per cycle without hazards.

Test Plan:
- Reset release, then 0x00500093 (addi x1,x0,5) with ex_ready_i=1 → next cycle ctrl_valid_o=1, alu_op=1, alu_src=1, reg_write=1, rd_o=1, rd2=0.
- 0x401101B3 (sub x3,x2,x1) → alu_op=2, rd1=rd2=1, alu_src=0. An SLL R-type word → alu_src=0, rd2=1.
- 0x0000A103 (lw x2,0(x1)) then 0x001101B3 (add x3,x2,x1) back to back → the add sees inst_ready_o=0 for one cycle, a bubble is registered, stall_cnt_o=1, then the add issues with alu_op=1.
- 0x022081B3 (mul) with EN_MEXT=1 → alu_op=20. With EN_MEXT=0 → illegal_o=1, reg_write=0.
- ex_ready_i=0 for 3 cycles with a valid output → outputs stable, inst_ready_o=0, issue_cnt_o unchanged. flush_i in the middle → ctrl_valid_o=0 next cycle.
- Assert rst_i=0 mid-stream, asynchronously → all outputs and counters 0 immediately without waiting for a clock. Force issue_cnt_o to wrap with CNT_W=4 → 15 rolls to 0.
